pwm_duty_ramp: RTL and testbench



---
 rtl/pwm_duty_ramp.sv | 113 +++++++++++
 tb/tb_pwm_duty_ramp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// rtl/pwm_duty_ramp.sv - slews a registered PWM duty toward an accepted target, one step per period boundary
module pwm_duty_ramp #(
    parameter int R    = 4,
    parameter int STEP = 1,
    parameter int DIV  = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [R-1:0] i_target,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [R-1:0] o_duty,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_period_end
);

    localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [R:0]    STEP_W   = (R + 1)'(STEP);
    localparam logic [R-1:0]  STEP_R   = R'(STEP);
    localparam logic [0:0]    IDLE     = 1'b0;
    localparam logic [0:0]    RAMP     = 1'b1;

    logic [R-1:0]  cnt_q, cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic [0:0]    state_q, state_d;
    logic [R-1:0]  duty_q, duty_d;
    logic [R-1:0]  target_q, target_d;
    logic          done_q, done_d;

    logic          period_end;
    logic          xfer;
    logic          step;
    logic [R:0]    diff_up;
    logic [R:0]    diff_dn;
    logic [R-1:0]  next_duty;

    assign period_end = (cnt_q == {R{1'b1}});
    assign xfer       = i_valid && (state_q == IDLE);
    assign step       = (state_q == RAMP) && period_end && (div_q == DIV_LAST);

    // Distances are taken one bit wider so the saturation test cannot wrap.
    always_comb begin
        diff_up   = {1'b0, target_q} - {1'b0, duty_q};
        diff_dn   = {1'b0, duty_q} - {1'b0, target_q};
        next_duty = duty_q;
        if (target_q > duty_q) begin
            next_duty = (diff_up <= STEP_W) ? target_q : duty_q + STEP_R;
        end else begin
            next_duty = (diff_dn <= STEP_W) ? target_q : duty_q - STEP_R;
        end
    end

    always_comb begin
        cnt_d    = cnt_q + R'(1);
        div_d    = div_q;
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    target_d = i_target;
                    if (i_target == duty_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RAMP;
                        div_d   = '0;
                    end
                end
            end
            default: begin
                if (period_end) begin
                    div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
                end
                if (step) begin
                    duty_d = next_duty;
                    if (next_duty == target_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            div_q    <= '0;
            state_q  <= IDLE;
            duty_q   <= '0;
            target_q <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            done_q   <= done_d;
        end
    end

    assign o_ready      = (state_q == IDLE);
    assign o_busy       = (state_q == RAMP);
    assign o_duty       = duty_q;
    assign o_done       = done_q;
    assign o_period_end = period_end;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb/tb_pwm_duty_ramp.sv - scoreboard bench for pwm_duty_ramp across three parameter sets
module tb_pwm_duty_ramp;

    typedef struct {
        int         k;
        logic [3:0] duty;
        logic       done;
        int         at;
    } evt_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] tgt  [3];
    logic       vld  [3];
    logic       rdy  [3];
    logic [3:0] duty [3];
    logic       busy [3];
    logic       done [3];
    logic       pe   [3];

    evt_t       exp_q[$];
    evt_t       e;
    logic [3:0] prev [3];
    logic [3:0] mcnt;
    int         cyc;
    int         n_chk;
    int         n_err;
    bit         mon_en;

    pwm_duty_ramp #(.R(4), .STEP(1), .DIV(1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_target(tgt[0]), .i_valid(vld[0]),
        .o_ready(rdy[0]), .o_duty(duty[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_period_end(pe[0])
    );
    pwm_duty_ramp #(.R(4), .STEP(4), .DIV(1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_target(tgt[1]), .i_valid(vld[1]),
        .o_ready(rdy[1]), .o_duty(duty[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_period_end(pe[1])
    );
    pwm_duty_ramp #(.R(4), .STEP(1), .DIV(3)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_target(tgt[2]), .i_valid(vld[2]),
        .o_ready(rdy[2]), .o_duty(duty[2]), .o_busy(busy[2]), .o_done(done[2]),
        .o_period_end(pe[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc  = 0;
        mcnt = 4'd0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (!rst_n) mcnt = 4'd0;
            else        mcnt = mcnt + 4'd1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: period-end cadence every cycle, and every duty change or done pulse against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int k = 0; k < 3; k++) begin
                    n_chk = n_chk + 1;
                    if (pe[k] !== (mcnt == 4'd15)) begin
                        n_err = n_err + 1;
                        $display("FAIL period_end inst=%0d cyc=%0d got=%0b expected=%0b", k, cyc, pe[k], mcnt == 4'd15);
                    end
                    if (duty[k] !== prev[k] || done[k] !== 1'b0) begin
                        n_chk = n_chk + 1;
                        if (exp_q.size() == 0) begin
                            n_err = n_err + 1;
                            $display("FAIL unexpected_event inst=%0d cyc=%0d duty=%0d done=%0b expected none",
                                     k, cyc, duty[k], done[k]);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.k != k || e.duty !== duty[k] || e.done !== done[k] || (e.at >= 0 && e.at != cyc)) begin
                                n_err = n_err + 1;
                                $display("FAIL event got inst=%0d duty=%0d done=%0b cyc=%0d expected inst=%0d duty=%0d done=%0b at=%0d",
                                         k, duty[k], done[k], cyc, e.k, e.duty, e.done, e.at);
                            end
                        end
                    end
                end
            end
            for (int k = 0; k < 3; k++) prev[k] = duty[k];
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_chk = n_chk + 1;
        if (got !== expv) begin
            n_err = n_err + 1;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, expv);
        end
    endtask

    task automatic push(input int k, input logic [3:0] d, input logic dn, input int at);
        evt_t x;
        x.k = k; x.duty = d; x.done = dn; x.at = at;
        exp_q.push_back(x);
    endtask

    // Drives one request; with align set, the transfer edge is an o_period_end edge.
    task automatic send(input int k, input logic [3:0] t, input bit align, output int te);
        int n;
        n = 0;
        @(negedge clk);
        while (!(rdy[k] && (!align || pe[k])) && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_timeout", 32'(n < 64), 32'd1);
        tgt[k] = t;
        vld[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        te     = cyc;
        vld[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int n;
        n = 0;
        while (done[k] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(n < budget), 32'd1);
        chk("ready_with_done", 32'(rdy[k]), 32'd1);
        chk("busy_with_done", 32'(busy[k]), 32'd0);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int t;
        n_chk  = 0;
        n_err  = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0;
            tgt[k] = 4'd0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_duty", 32'(duty[k]), 32'd0);
            chk("reset_ready", 32'(rdy[k]), 32'd1);
            chk("reset_busy", 32'(busy[k]), 32'd0);
            chk("reset_done", 32'(done[k]), 32'd0);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // STEP=4: 0->13, then 13->2 saturating at 2, then 2->15 saturating at 15.
        send(1, 4'd13, 1'b1, t);
        push(1, 4'd4, 1'b0, t + 16); push(1, 4'd8, 1'b0, t + 32);
        push(1, 4'd12, 1'b0, t + 48); push(1, 4'd13, 1'b1, t + 64);
        wait_done(1, 100);
        send(1, 4'd2, 1'b1, t);
        push(1, 4'd9, 1'b0, t + 16); push(1, 4'd5, 1'b0, t + 32); push(1, 4'd2, 1'b1, t + 48);
        wait_done(1, 80);
        send(1, 4'd15, 1'b1, t);
        push(1, 4'd6, 1'b0, t + 16); push(1, 4'd10, 1'b0, t + 32);
        push(1, 4'd14, 1'b0, t + 48); push(1, 4'd15, 1'b1, t + 64);
        wait_done(1, 100);

        // DIV=3, accepted on a period-end edge: first step three boundaries later.
        send(2, 4'd2, 1'b1, t);
        push(2, 4'd1, 1'b0, t + 48); push(2, 4'd2, 1'b1, t + 96);
        wait_done(2, 130);

        // STEP=1: 0->3, 3->5, then an equal-target request.
        send(0, 4'd3, 1'b1, t);
        push(0, 4'd1, 1'b0, t + 16); push(0, 4'd2, 1'b0, t + 32); push(0, 4'd3, 1'b1, t + 48);
        wait_done(0, 80);
        send(0, 4'd5, 1'b1, t);
        push(0, 4'd4, 1'b0, t + 16); push(0, 4'd5, 1'b1, t + 32);
        wait_done(0, 60);
        push(0, 4'd5, 1'b1, -1);
        send(0, 4'd5, 1'b0, t);
        chk("equal_done_pulse", 32'(done[0]), 32'd1);
        chk("equal_busy", 32'(busy[0]), 32'd0);
        chk("equal_duty", 32'(duty[0]), 32'd5);
        @(negedge clk);
        chk("equal_done_single", 32'(done[0]), 32'd0);
        chk("equal_busy_after", 32'(busy[0]), 32'd0);

        // Ramp toward 12, ignored request during the ramp, then reset mid-ramp.
        send(0, 4'd12, 1'b1, t);
        push(0, 4'd6, 1'b0, t + 16); push(0, 4'd7, 1'b0, t + 32);
        wait_cyc(t + 20);
        tgt[0] = 4'd0;
        vld[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ramp_not_ready", 32'(rdy[0]), 32'd0);
            chk("ramp_busy", 32'(busy[0]), 32'd1);
        end
        vld[0] = 1'b0;
        wait_cyc(t + 34);
        push(0, 4'd0, 1'b0, -1); push(1, 4'd0, 1'b0, -1); push(2, 4'd0, 1'b0, -1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_duty", 32'(duty[0]), 32'd0);
        chk("midreset_ready", 32'(rdy[0]), 32'd1);
        chk("midreset_busy", 32'(busy[0]), 32'd0);
        chk("midreset_done", 32'(done[0]), 32'd0);
        repeat (40) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
